lcd_cmd_queue: RTL and testbench

//  Bus-side front end for the character LCD controller. The CPU bus writes characters and
//  HD44780 instructions into a DEPTH-entry FIFO of {rs, byte} entries.
//  The downstream LCD timing engine drains the FIFO one entry at a time over a valid/ready handshake.

---
 rtl/lcd_cmd_queue_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 49 ++++
 rtl/lcd_cmd_queue.sv | 111 +++++++++++
 tb/tb_lcd_cmd_queue.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_cmd_queue_pkg.sv
// Shared definitions for the LCD command queue: register map, STATUS bit positions, FIFO entry layout.
package lcd_cmd_queue_pkg;

    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned ENTRY_W = 9;

    localparam logic [ADDR_W-1:0] LCD_REG_DATA   = 6'h00;
    localparam logic [ADDR_W-1:0] LCD_REG_INSTR  = 6'h01;
    localparam logic [ADDR_W-1:0] LCD_REG_STATUS = 6'h02;
    localparam logic [ADDR_W-1:0] LCD_REG_CTRL   = 6'h03;

    localparam int unsigned STS_EMPTY     = 0;
    localparam int unsigned STS_FULL      = 1;
    localparam int unsigned STS_OVF       = 2;
    localparam int unsigned STS_COUNT_LSB = 8;

    localparam int unsigned CTRL_ON    = 0;
    localparam int unsigned CTRL_FLUSH = 1;

    typedef struct packed {
        logic              rs;
        logic [BYTE_W-1:0] data;
    } lcd_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush; head is read combinationally.
module sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head_c,
    output logic [AW:0]      count,
    output logic             full_c,
    output logic             empty_c
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full_c  = (count == (AW+1)'(DEPTH));
    assign empty_c = (count == '0);
    assign head_c  = mem[rd_ptr];

    // Flush overrides both push and pop on the same edge.
    assign do_push = push && !full_c && !flush;
    assign do_pop  = pop && !empty_c && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/lcd_cmd_queue.sv
// Bus-side front end of the character LCD controller: command FIFO, status/control registers.
module lcd_cmd_queue
    import lcd_cmd_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    input  logic [3:0]        be,
    output logic [DATA_W-1:0] readdata,
    output logic              cmd_valid,
    output logic              cmd_rs,
    output logic [BYTE_W-1:0] cmd_data,
    input  logic              cmd_ready,
    output logic              on
);

    logic              wr_en;
    logic              is_data;
    logic              is_instr;
    logic              is_status;
    logic              is_ctrl;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic              fifo_full;
    logic              fifo_empty;
    logic [AW:0]       fifo_count;
    logic              overflow;
    lcd_entry_t        push_entry;
    lcd_entry_t        head_entry;
    logic [DATA_W-1:0] rd_mux_c;
    logic              unused_bits;

    assign wr_en     = write && be[0];
    assign is_data   = (address == LCD_REG_DATA);
    assign is_instr  = (address == LCD_REG_INSTR);
    assign is_status = (address == LCD_REG_STATUS);
    assign is_ctrl   = (address == LCD_REG_CTRL);

    assign fifo_push  = wr_en && (is_data || is_instr);
    assign fifo_flush = wr_en && is_ctrl && writedata[CTRL_FLUSH];
    assign fifo_pop   = cmd_valid && cmd_ready;

    assign push_entry.rs   = is_data;
    assign push_entry.data = writedata[BYTE_W-1:0];

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (fifo_flush),
        .wdata   (push_entry),
        .head_c  (head_entry),
        .count   (fifo_count),
        .full_c  (fifo_full),
        .empty_c (fifo_empty)
    );

    assign cmd_valid = !fifo_empty;
    assign cmd_rs    = head_entry.rs;
    assign cmd_data  = head_entry.data;

    // Overflow is sticky; a drop on the same edge as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            on       <= 1'b0;
        end else begin
            if (fifo_push && fifo_full) begin
                overflow <= 1'b1;
            end else if (wr_en && is_status && writedata[STS_OVF]) begin
                overflow <= 1'b0;
            end
            if (wr_en && is_ctrl) on <= writedata[CTRL_ON];
        end
    end

    always_comb begin
        rd_mux_c = '0;
        if (is_status) begin
            rd_mux_c[STS_EMPTY]                   = fifo_empty;
            rd_mux_c[STS_FULL]                    = fifo_full;
            rd_mux_c[STS_OVF]                     = overflow;
            rd_mux_c[STS_COUNT_LSB +: (AW+1)]     = fifo_count;
        end else if (is_ctrl) begin
            rd_mux_c[CTRL_ON]                     = on;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            readdata <= '0;
        end else if (read) begin
            readdata <= rd_mux_c;
        end
    end

    assign unused_bits = ^{writedata[DATA_W-1:BYTE_W], be[3:1]};

endmodule

// File: tb/tb_lcd_cmd_queue.sv
// Self-checking bench for lcd_cmd_queue: vector table plus scoreboard of queued LCD entries.
module tb_lcd_cmd_queue;

    localparam int unsigned DEPTH = 16;

    localparam int OP_WR    = 0;
    localparam int OP_RD    = 1;
    localparam int OP_POP   = 2;
    localparam int OP_VALID = 3;
    localparam int OP_ON    = 4;

    localparam logic [5:0] A_DATA   = 6'h00;
    localparam logic [5:0] A_INSTR  = 6'h01;
    localparam logic [5:0] A_STATUS = 6'h02;
    localparam logic [5:0] A_CTRL   = 6'h03;

    typedef struct {
        int          op;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        read;
    logic        write;
    logic [5:0]  address;
    logic [31:0] writedata;
    logic [3:0]  be;
    logic [31:0] readdata;
    logic        cmd_valid;
    logic        cmd_rs;
    logic [7:0]  cmd_data;
    logic        cmd_ready;
    logic        on;

    int          n_pass;
    int          n_tot;
    logic [8:0]  sb[$];
    vec_t        vecs[$];

    lcd_cmd_queue #(.DEPTH(DEPTH), .AW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .read      (read),
        .write     (write),
        .address   (address),
        .writedata (writedata),
        .be        (be),
        .readdata  (readdata),
        .cmd_valid (cmd_valid),
        .cmd_rs    (cmd_rs),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .on        (on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    function automatic vec_t mk(input int op, input logic [5:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be_v, input logic [31:0] exp);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.be = be_v; v.exp = exp;
        return v;
    endfunction

    // Scoreboard mirrors what the bus write should enqueue or discard.
    task automatic sb_write(input logic [5:0] addr, input logic [31:0] wdata, input logic [3:0] be_v);
        if (be_v[0]) begin
            if (addr == A_DATA || addr == A_INSTR) begin
                if (sb.size() < DEPTH) sb.push_back({addr == A_DATA, wdata[7:0]});
            end else if (addr == A_CTRL && wdata[1]) begin
                sb.delete();
            end
        end
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [31:0] wdata, input logic [3:0] be_v);
        address = addr; writedata = wdata; be = be_v; write = 1'b1;
        @(posedge clk);
        sb_write(addr, wdata, be_v);
        @(negedge clk);
        write = 1'b0; be = 4'h0;
    endtask

    task automatic do_read(input logic [5:0] addr, input logic [31:0] exp, input string name);
        address = addr; read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        read = 1'b0;
        check(name, readdata, exp);
    endtask

    task automatic check_head(input string name);
        check({name, "_valid"}, {31'b0, cmd_valid}, {31'b0, sb.size() != 0});
        if (sb.size() != 0) check({name, "_head"}, {23'b0, cmd_rs, cmd_data}, {23'b0, sb[0]});
    endtask

    task automatic do_pop(input string name);
        check_head(name);
        cmd_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_ready = 1'b0;
        if (sb.size() != 0) void'(sb.pop_front());
    endtask

    // DATA write and pop on the same edge; the push is judged against occupancy before the edge.
    task automatic push_pop(input logic [7:0] d, input string name);
        logic was_full;
        check_head(name);
        was_full = (sb.size() == DEPTH);
        address = A_DATA; writedata = {24'h0, d}; be = 4'hF; write = 1'b1; cmd_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        write = 1'b0; cmd_ready = 1'b0; be = 4'h0;
        if (sb.size() != 0) void'(sb.pop_front());
        if (!was_full) sb.push_back({1'b1, d});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    initial begin
        n_pass = 0; n_tot = 0;
        rst = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        be = 4'h0; cmd_ready = 1'b0;
        @(negedge clk);
        do_reset();
        check("reset_readdata", readdata, 32'h0);

        vecs.push_back(mk(OP_RD,    A_STATUS, 0,      4'hF, 32'h0000_0001));
        vecs.push_back(mk(OP_VALID, 0,        0,      4'hF, 32'h0));
        vecs.push_back(mk(OP_ON,    0,        0,      4'hF, 32'h0));
        vecs.push_back(mk(OP_WR,    A_INSTR,  32'h01, 4'hF, 0));
        vecs.push_back(mk(OP_WR,    A_DATA,   32'h41, 4'hF, 0));
        vecs.push_back(mk(OP_VALID, 0,        0,      4'hF, 32'h1));
        vecs.push_back(mk(OP_RD,    A_STATUS, 0,      4'hF, 32'h0000_0200));
        vecs.push_back(mk(OP_POP,   0,        0,      4'hF, 0));
        vecs.push_back(mk(OP_POP,   0,        0,      4'hF, 0));
        vecs.push_back(mk(OP_RD,    A_STATUS, 0,      4'hF, 32'h0000_0001));
        vecs.push_back(mk(OP_WR,    A_DATA,   32'h61, 4'hF, 0));
        vecs.push_back(mk(OP_WR,    A_INSTR,  32'h62, 4'hF, 0));
        vecs.push_back(mk(OP_WR,    A_DATA,   32'h63, 4'hF, 0));
        vecs.push_back(mk(OP_RD,    A_STATUS, 0,      4'hF, 32'h0000_0300));
        vecs.push_back(mk(OP_WR,    A_CTRL,   32'h3,  4'hF, 0));
        vecs.push_back(mk(OP_VALID, 0,        0,      4'hF, 32'h0));
        vecs.push_back(mk(OP_ON,    0,        0,      4'hF, 32'h1));
        vecs.push_back(mk(OP_RD,    A_STATUS, 0,      4'hF, 32'h0000_0001));
        vecs.push_back(mk(OP_RD,    A_CTRL,   0,      4'hF, 32'h0000_0001));
        vecs.push_back(mk(OP_WR,    A_DATA,   32'h55, 4'hE, 0));
        vecs.push_back(mk(OP_VALID, 0,        0,      4'hF, 32'h0));
        vecs.push_back(mk(OP_RD,    A_STATUS, 0,      4'hF, 32'h0000_0001));
        vecs.push_back(mk(OP_RD,    6'h05,    0,      4'hF, 32'h0));
        vecs.push_back(mk(OP_WR,    A_CTRL,   32'h0,  4'hE, 0));
        vecs.push_back(mk(OP_ON,    0,        0,      4'hF, 32'h1));

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_WR:    do_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
                OP_RD:    do_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_read", i));
                OP_POP:   do_pop($sformatf("vec%0d_pop", i));
                OP_VALID: check($sformatf("vec%0d_valid", i), {31'b0, cmd_valid}, vecs[i].exp);
                OP_ON:    check($sformatf("vec%0d_on", i), {31'b0, on}, vecs[i].exp);
                default:  check($sformatf("vec%0d_op", i), 32'(vecs[i].op), 32'h0);
            endcase
        end

        // Overflow: 17th DATA write is dropped, 16 entries drain in order.
        for (int i = 0; i < 17; i++) do_write(A_DATA, 32'(8'h30 + i), 4'hF);
        do_read(A_STATUS, 32'h0000_1006, "ovf_status");
        for (int i = 0; i < 16; i++) do_pop($sformatf("drain%0d", i));
        check("drain_empty", {31'b0, cmd_valid}, 32'h0);
        do_read(A_STATUS, 32'h0000_0005, "ovf_sticky");
        do_write(A_STATUS, 32'h4, 4'hF);
        do_read(A_STATUS, 32'h0000_0001, "ovf_clear");

        // Steady count of 5 with simultaneous push/pop across the pointer wrap.
        for (int i = 0; i < 5; i++) do_write(A_DATA, 32'(8'h70 + i), 4'hF);
        for (int i = 0; i < 15; i++) push_pop(8'(8'h80 + i), $sformatf("pp%0d", i));
        do_read(A_STATUS, 32'h0000_0500, "pp_status");
        for (int i = 0; i < 5; i++) do_pop($sformatf("wrap%0d", i));
        check("wrap_empty", {31'b0, cmd_valid}, 32'h0);

        // Full FIFO with a pop on the same edge still drops the push and flags overflow.
        for (int i = 0; i < 16; i++) do_write(A_INSTR, 32'(8'hA0 + i), 4'hF);
        push_pop(8'hEE, "full_pp");
        do_read(A_STATUS, 32'h0000_0F04, "full_pp_status");
        check_head("full_pp_head");

        // Reset with entries queued, overflow set and power on.
        do_write(A_CTRL, 32'h1, 4'hF);
        do_reset();
        check("rst_valid", {31'b0, cmd_valid}, 32'h0);
        check("rst_on", {31'b0, on}, 32'h0);
        check("rst_readdata", readdata, 32'h0);
        do_read(A_STATUS, 32'h0000_0001, "rst_status");
        do_write(A_DATA, 32'h5A, 4'hF);
        check_head("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
